// File: rtl/sequencia_jogadas_if.sv
// Pattern ROM bus between the sequence checker (master) and the 16x4 pattern ROM (slave).
// The ROM is registered: rom_data reflects the endereco sampled on the previous rising edge.
interface sequencia_jogadas_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4
);
  logic [ADDR_W-1:0] endereco;
  logic [DATA_W-1:0] rom_data;

  modport master (output endereco, input rom_data);
  modport slave  (input endereco, output rom_data);
endinterface

// File: rtl/sequencia_jogadas.sv
// Game-sequence checker: walks ROM addresses 0..limite, waits for one button press per step
// and ends the round in success, error or timeout.
module sequencia_jogadas #(
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 4,
  parameter int TIMEOUT = 5000
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                iniciar,
  input  logic [ADDR_W-1:0]   limite,
  input  logic [DATA_W-1:0]   botoes,
  sequencia_jogadas_if.master rom,
  output logic                pronto,
  output logic                acertou,
  output logic                errou,
  output logic                timeout,
  output logic [DATA_W-1:0]   db_jogada,
  output logic [3:0]          db_estado
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    INICIAL     = 4'h0,
    PREPARA     = 4'h1,
    ESPERA      = 4'h2,
    COMPARA     = 4'h3,
    PROXIMO     = 4'h4,
    FIM_ACERTO  = 4'hA,
    FIM_ERRO    = 4'hE,
    FIM_TIMEOUT = 4'hF
  } estado_t;

  estado_t           state;
  estado_t           next_state;
  logic [ADDR_W-1:0] endereco;
  logic [ADDR_W-1:0] limite_reg;
  logic [DATA_W-1:0] jogada_reg;
  logic [DATA_W-1:0] botoes_prev;
  logic [TW-1:0]     timer;
  logic              jogada;

  // A press is a rising edge of "any key down"; a held key never counts twice.
  assign jogada = (botoes != '0) && (botoes_prev == '0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= INICIAL;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      INICIAL: if (iniciar) next_state = PREPARA;
      PREPARA: next_state = ESPERA;
      ESPERA: begin
        if (jogada)                   next_state = COMPARA;
        else if (timer == TIMER_LAST) next_state = FIM_TIMEOUT;
      end
      COMPARA: begin
        if (jogada_reg != rom.rom_data) next_state = FIM_ERRO;
        else if (endereco == limite_reg) next_state = FIM_ACERTO;
        else                             next_state = PROXIMO;
      end
      PROXIMO: next_state = ESPERA;
      FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT: if (iniciar) next_state = PREPARA;
      default: next_state = INICIAL;
    endcase
  end

  always_comb begin
    pronto  = 1'b0;
    acertou = 1'b0;
    errou   = 1'b0;
    timeout = 1'b0;
    case (state)
      FIM_ACERTO:  begin pronto = 1'b1; acertou = 1'b1; end
      FIM_ERRO:    begin pronto = 1'b1; errou   = 1'b1; end
      FIM_TIMEOUT: begin pronto = 1'b1; timeout = 1'b1; end
      default:     ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      endereco    <= '0;
      limite_reg  <= '0;
      jogada_reg  <= '0;
      botoes_prev <= '0;
      timer       <= '0;
    end else begin
      botoes_prev <= botoes;
      case (state)
        PREPARA: begin
          endereco   <= '0;
          limite_reg <= limite;
          timer      <= '0;
        end
        ESPERA: begin
          if (jogada) jogada_reg <= botoes;
          else        timer      <= timer + 1'b1;
        end
        // limite_reg bounds endereco, so the increment never wraps.
        PROXIMO: begin
          endereco <= endereco + 1'b1;
          timer    <= '0;
        end
        default: ;
      endcase
    end
  end

  assign rom.endereco = endereco;
  assign db_jogada    = jogada_reg;
  assign db_estado    = state;

endmodule

// File: tb/tb_sequencia_jogadas.sv
// Directed bench for sequencia_jogadas with a registered 16x4 pattern ROM model.
module tb_sequencia_jogadas;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       iniciar;
  logic [3:0] limite;
  logic [3:0] botoes;
  logic       pronto, acertou, errou, timeout;
  logic [3:0] db_jogada;
  logic [3:0] db_estado;

  int n_cmp = 0;
  int n_err = 0;

  logic [3:0] rom_tab [16] = '{4'd1, 4'd1, 4'd2, 4'd2, 4'd4, 4'd4, 4'd8, 4'd8,
                               4'd4, 4'd4, 4'd2, 4'd2, 4'd1, 4'd1, 4'd2, 4'd2};

  sequencia_jogadas_if #(.ADDR_W(4), .DATA_W(4)) rom_bus ();

  sequencia_jogadas #(.ADDR_W(4), .DATA_W(4), .TIMEOUT(20)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .iniciar   (iniciar),
    .limite    (limite),
    .botoes    (botoes),
    .rom       (rom_bus.master),
    .pronto    (pronto),
    .acertou   (acertou),
    .errou     (errou),
    .timeout   (timeout),
    .db_jogada (db_jogada),
    .db_estado (db_estado)
  );

  // Clock / reset
  always #5 clock = ~clock;

  always @(posedge clock) rom_bus.rom_data <= rom_tab[rom_bus.endereco];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Press and release one key pattern; leaves the DUT one clock after the verdict state.
  task automatic press(input logic [3:0] val, input string tag);
    botoes = val;
    tick(1);
    check({tag, "_compara"}, db_estado, 32'h3);
    botoes = 4'd0;
    tick(1);
  endtask

  // Start a round from INICIAL or a FIM_* state; returns in the first ESPERA cycle.
  task automatic start_round(input logic [3:0] lim);
    limite  = lim;
    iniciar = 1'b1;
    tick(1);
    iniciar = 1'b0;
    tick(1);
  endtask

  initial begin
    reset_n = 1'b0;
    iniciar = 1'b0;
    limite  = 4'd0;
    botoes  = 4'd0;
    rom_bus.rom_data = 4'd0;
    tick(2);
    check("rst_estado", db_estado, 32'h0);
    check("rst_endereco", rom_bus.endereco, 32'h0);
    check("rst_pronto", pronto, 32'h0);
    reset_n = 1'b1;
    tick(1);

    // Full 4-step round with correct presses
    start_round(4'd3);
    check("t2_espera", db_estado, 32'h2);
    press(4'd1, "t2_p0"); check("t2_proximo", db_estado, 32'h4); tick(1);
    press(4'd1, "t2_p1"); tick(1);
    press(4'd2, "t2_p2"); tick(1);
    check("t2_endereco_mid", rom_bus.endereco, 32'h3);
    press(4'd2, "t2_p3");
    check("t2_estado", db_estado, 32'hA);
    check("t2_acertou", acertou, 32'h1);
    check("t2_pronto", pronto, 32'h1);
    check("t2_errou", errou, 32'h0);
    check("t2_endereco", rom_bus.endereco, 32'h3);

    // Wrong key at step 2, with a stray iniciar during ESPERA
    start_round(4'd15);
    check("t3_acertou_clr", acertou, 32'h0);
    check("t3_endereco0", rom_bus.endereco, 32'h0);
    press(4'd1, "t3_p0"); tick(1);
    press(4'd1, "t3_p1"); tick(1);
    iniciar = 1'b1;
    tick(1);
    iniciar = 1'b0;
    check("t6_ini_ignored", db_estado, 32'h2);
    press(4'd4, "t3_p2");
    check("t3_estado", db_estado, 32'hE);
    check("t3_errou", errou, 32'h1);
    check("t3_endereco", rom_bus.endereco, 32'h2);
    check("t3_jogada", db_jogada, 32'h4);

    // iniciar in FIM_ERRO restarts; single-step round that times out
    limite  = 4'd0;
    iniciar = 1'b1;
    tick(1);
    iniciar = 1'b0;
    check("t6_prepara", db_estado, 32'h1);
    check("t6_errou_clr", errou, 32'h0);
    check("t6_pronto_clr", pronto, 32'h0);
    tick(1);
    check("t6_endereco0", rom_bus.endereco, 32'h0);
    tick(18);
    check("t4_cycle19", db_estado, 32'h2);
    tick(1);
    check("t4_cycle20", db_estado, 32'h2);
    check("t4_no_to_yet", timeout, 32'h0);
    tick(1);
    check("t4_estado", db_estado, 32'hF);
    check("t4_timeout", timeout, 32'h1);
    check("t4_pronto", pronto, 32'h1);

    // Press on the expiry cycle wins over the timeout
    start_round(4'd0);
    tick(19);
    press(4'd1, "t4_late");
    check("t4_late_estado", db_estado, 32'hA);
    check("t4_late_timeout", timeout, 32'h0);

    // Asynchronous reset in the middle of ESPERA
    start_round(4'd3);
    press(4'd1, "t1_p0"); tick(1);
    check("t1_pre_endereco", rom_bus.endereco, 32'h1);
    #2 reset_n = 1'b0;
    #1;
    check("t1_estado", db_estado, 32'h0);
    check("t1_endereco", rom_bus.endereco, 32'h0);
    check("t1_pronto", pronto, 32'h0);
    check("t1_jogada", db_jogada, 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    tick(1);

    // Key held across a step must be released before it counts again
    start_round(4'd3);
    botoes = 4'd1;
    tick(1);
    check("t5_compara", db_estado, 32'h3);
    tick(1);
    check("t5_proximo", db_estado, 32'h4);
    tick(4);
    check("t5_held_wait", db_estado, 32'h2);
    botoes = 4'd0;
    tick(1);
    press(4'b0011, "t5_multi");
    check("t5_estado", db_estado, 32'hE);
    check("t5_errou", errou, 32'h1);
    check("t5_endereco", rom_bus.endereco, 32'h1);
    check("t5_jogada", db_jogada, 32'h3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
